pingpong_symbol_buffer: RTL

- Stage directly downstream of the modulation mapper in the PUSCH chain.
- Captures mapped I/Q symbols into one of two 1200-entry banks.
- When the mapper reports a bank done, the bank is handed to the read side. The read side streams the bank to transform precoding over a valid/ready handshake.
- Writing continues into the other bank, so mapping and readout overlap.

---
 rtl/pusch_pkg.sv | 27 ++
 rtl/symbuf_bank_ram.sv | 28 ++
 rtl/pingpong_symbol_buffer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pusch_pkg.sv
// Shared constants and types for the PUSCH symbol buffer: sample widths, bank depth,
// read-side FSM states and the packed I/Q sample.
package pusch_pkg;

  localparam int unsigned LUT_WIDTH = 18;
  localparam int unsigned DEPTH     = 1200;
  localparam int unsigned ADDR_W    = 11;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StRelease
  } rd_state_e;

  typedef struct packed {
    logic signed [LUT_WIDTH-1:0] i;
    logic signed [LUT_WIDTH-1:0] q;
  } sample_t;

  // Symbol count reported by the mapper, limited to what a bank can hold.
  function automatic logic [ADDR_W-1:0] clamp_count(input logic [ADDR_W-1:0] n);
    logic [ADDR_W-1:0] depth_a;
    depth_a = ADDR_W'(DEPTH);
    return (n > depth_a) ? depth_a : n;
  endfunction

endpackage

// File: rtl/symbuf_bank_ram.sv
// One symbol bank: single write port, single registered read port, no reset on the array.
module symbuf_bank_ram #(
  parameter int unsigned Depth = 1200,
  parameter int unsigned Width = 36,
  parameter int unsigned AddrW = 11
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AddrW-1:0] wr_addr,
  input  logic [Width-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AddrW-1:0] rd_addr,
  output logic [Width-1:0] rd_data
);

  logic [Width-1:0] mem [Depth];

  // Storage write and one-cycle registered read; read data holds when not enabled.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/pingpong_symbol_buffer.sv
// Ping-pong buffer between the modulation mapper and transform precoding.
// The mapper fills one bank while the other is streamed out over valid/ready.
// Optional status counters (frames released, writes dropped) are enabled with the
// SYMBUF_STATUS_EN macro; without it those ports do not exist.
module pingpong_symbol_buffer
  import pusch_pkg::*;
(
  input  logic                 CLK_Buf,
  input  logic                 RST_Buf,
  input  logic                 Wr_Valid_IN,
  input  logic [ADDR_W-1:0]    Wr_addr_IN,
  input  logic [LUT_WIDTH-1:0] Wr_I_IN,
  input  logic [LUT_WIDTH-1:0] Wr_Q_IN,
  input  logic                 Bank_Done_IN,
  input  logic [ADDR_W-1:0]    Last_addr_IN,
  input  logic                 Rd_Ready_IN,
  output logic                 Rd_Valid_OUT,
  output logic [LUT_WIDTH-1:0] Rd_I_OUT,
  output logic [LUT_WIDTH-1:0] Rd_Q_OUT,
  output logic                 Rd_Last_OUT,
  output logic [ADDR_W-1:0]    Rd_Count_OUT,
  output logic [1:0]           Bank_Full_OUT,
  output logic                 Wr_Bank_OUT,
  output logic                 Overflow_OUT
`ifdef SYMBUF_STATUS_EN
  ,
  output logic [15:0]          Frame_Cnt_OUT,
  output logic [15:0]          Drop_Cnt_OUT
`endif
);

  localparam logic [ADDR_W-1:0] DepthA = ADDR_W'(DEPTH);

  // Write side state
  logic              wr_bank_q;
  logic [1:0]        bank_full_q;
  logic [ADDR_W-1:0] bank_cnt_q [2];
  logic              overflow_q;

  logic              blocked;
  logic              wr_en;
  logic              done_fire;
  logic              release_now;
  logic [ADDR_W-1:0] done_cnt;
  sample_t           wr_sample;

  // Read side state
  rd_state_e         state_q;
  logic              rd_bank_q;
  logic [ADDR_W-1:0] rd_count_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              inflight_q;
  logic              inflight_last_q;
  sample_t           out_q;
  logic              out_valid_q;
  logic              out_last_q;
  sample_t           skid_q;
  logic              skid_valid_q;
  logic              skid_last_q;

  logic              issue;
  logic              issue_last;
  logic [ADDR_W-1:0] issue_addr;
  logic [ADDR_W-1:0] cur_count;
  logic              pop;
  logic [1:0]        fill;
  logic [1:0]        fill_limit;
  logic [2*LUT_WIDTH-1:0] ram_rd [2];
  sample_t           rd_sample;

  assign blocked     = bank_full_q[wr_bank_q];
  assign wr_en       = Wr_Valid_IN && !blocked && (Wr_addr_IN < DepthA);
  assign done_cnt    = clamp_count(Last_addr_IN);
  assign done_fire   = Bank_Done_IN && !blocked && (done_cnt != '0);
  assign release_now = (state_q == StRelease);
  assign wr_sample   = '{i: Wr_I_IN, q: Wr_Q_IN};
  assign rd_sample   = rd_bank_q ? sample_t'(ram_rd[1]) : sample_t'(ram_rd[0]);

  symbuf_bank_ram #(
    .Depth(DEPTH),
    .Width(2 * LUT_WIDTH),
    .AddrW(ADDR_W)
  ) u_bank0 (
    .clk    (CLK_Buf),
    .wr_en  (wr_en && !wr_bank_q),
    .wr_addr(Wr_addr_IN),
    .wr_data(wr_sample),
    .rd_en  (issue && !rd_bank_q),
    .rd_addr(issue_addr),
    .rd_data(ram_rd[0])
  );

  symbuf_bank_ram #(
    .Depth(DEPTH),
    .Width(2 * LUT_WIDTH),
    .AddrW(ADDR_W)
  ) u_bank1 (
    .clk    (CLK_Buf),
    .wr_en  (wr_en && wr_bank_q),
    .wr_addr(Wr_addr_IN),
    .wr_data(wr_sample),
    .rd_en  (issue && rd_bank_q),
    .rd_addr(issue_addr),
    .rd_data(ram_rd[1])
  );

  // Read issue decision: a RAM read is launched only if its data is guaranteed a slot
  // in the two-entry output buffer when it returns next cycle.
  always_comb begin
    pop        = out_valid_q && Rd_Ready_IN;
    fill       = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, inflight_q};
    fill_limit = pop ? 2'd3 : 2'd2;
    cur_count  = (state_q == StIdle) ? bank_cnt_q[rd_bank_q] : rd_count_q;
    issue_addr = (state_q == StIdle) ? '0 : rd_addr_q;
    issue      = 1'b0;
    case (state_q)
      StIdle:  issue = bank_full_q[rd_bank_q];
      StRead:  issue = (rd_addr_q < rd_count_q) && (fill < fill_limit);
      default: issue = 1'b0;
    endcase
    issue_last = (issue_addr == cur_count - 1'b1);
  end

  // Write-side bookkeeping: bank ownership, full flags, counts and the sticky overflow.
  // A release and an accepted done never target the same bank: done needs the write
  // bank empty, release needs the read bank full.
  always_ff @(posedge CLK_Buf or negedge RST_Buf) begin
    if (!RST_Buf) begin
      wr_bank_q     <= 1'b0;
      bank_full_q   <= 2'b00;
      bank_cnt_q[0] <= '0;
      bank_cnt_q[1] <= '0;
      overflow_q    <= 1'b0;
    end else begin
      if (Wr_Valid_IN && blocked) begin
        overflow_q <= 1'b1;
      end
      if (release_now) begin
        bank_full_q[rd_bank_q] <= 1'b0;
      end
      if (done_fire) begin
        bank_full_q[wr_bank_q] <= 1'b1;
        bank_cnt_q[wr_bank_q]  <= done_cnt;
        wr_bank_q              <= ~wr_bank_q;
      end
    end
  end

  // Read FSM with RAM issue pointer and the two-entry output/skid buffer.
  always_ff @(posedge CLK_Buf or negedge RST_Buf) begin
    if (!RST_Buf) begin
      state_q         <= StIdle;
      rd_bank_q       <= 1'b0;
      rd_count_q      <= '0;
      rd_addr_q       <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      out_q           <= '0;
      out_valid_q     <= 1'b0;
      out_last_q      <= 1'b0;
      skid_q          <= '0;
      skid_valid_q    <= 1'b0;
      skid_last_q     <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_last_q <= issue_last;
      end

      if (!out_valid_q || pop) begin
        if (skid_valid_q) begin
          out_q        <= skid_q;
          out_last_q   <= skid_last_q;
          out_valid_q  <= 1'b1;
          skid_valid_q <= inflight_q;
          if (inflight_q) begin
            skid_q      <= rd_sample;
            skid_last_q <= inflight_last_q;
          end
        end else if (inflight_q) begin
          out_q       <= rd_sample;
          out_last_q  <= inflight_last_q;
          out_valid_q <= 1'b1;
        end else begin
          // Data registers keep the last sample when the stream runs dry.
          out_valid_q <= 1'b0;
        end
      end else if (inflight_q) begin
        skid_q       <= rd_sample;
        skid_last_q  <= inflight_last_q;
        skid_valid_q <= 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (bank_full_q[rd_bank_q]) begin
            rd_count_q <= bank_cnt_q[rd_bank_q];
            rd_addr_q  <= ADDR_W'(1);
            state_q    <= StRead;
          end
        end
        StRead: begin
          if (issue) begin
            rd_addr_q <= rd_addr_q + 1'b1;
          end
          if (pop && out_last_q) begin
            state_q <= StRelease;
          end
        end
        StRelease: begin
          rd_bank_q <= ~rd_bank_q;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SYMBUF_STATUS_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] drop_cnt_q;

  // Saturating status counters: banks released and writes dropped while blocked.
  always_ff @(posedge CLK_Buf or negedge RST_Buf) begin
    if (!RST_Buf) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (release_now && (frame_cnt_q != 16'hFFFF)) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (Wr_Valid_IN && blocked && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign Frame_Cnt_OUT = frame_cnt_q;
  assign Drop_Cnt_OUT  = drop_cnt_q;
`endif

  assign Rd_Valid_OUT  = out_valid_q;
  assign Rd_I_OUT      = out_q.i;
  assign Rd_Q_OUT      = out_q.q;
  assign Rd_Last_OUT   = out_valid_q && out_last_q;
  assign Rd_Count_OUT  = rd_count_q;
  assign Bank_Full_OUT = bank_full_q;
  assign Wr_Bank_OUT   = wr_bank_q;
  assign Overflow_OUT  = overflow_q;

endmodule
